mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the CPU's single-port memory between the instruction-fetch requester
//  and the load/store data requester. Up to one access is in flight at a time.
//  Sits between the control FSM (fetch / LDR / STR sequencing) and the memory
//  block. Handles grant, wait states and completion pulses; optionally aborts
//  hung accesses.
// PARAMETERS
//  ADDR_W       32   address width, both requesters and memory side
//  DATA_W       32   data width
//  TIMEOUT_CYC  16   cycles in ACCESS before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous reset, active high
//  if_req     in   1       fetch request; hold with if_addr stable until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       1-cycle pulse: fetch accepted, address latched
//  if_valid   out  1       1-cycle pulse: fetch complete, if_rdata valid
//  if_rdata   out  DATA_W  fetched word, held until next fetch completion
//  d_req      in   1       data request; hold with d_we/d_addr/d_wdata stable until d_gnt
//  d_we       in   1       1 = store (STR), 0 = load (LDR)
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       1-cycle pulse: data request accepted
//  d_valid    out  1       1-cycle pulse: data access complete
//  d_rdata    out  DATA_W  load data, updated only on load completion
//  err        out  1       with *_valid: access aborted by timeout
//  busy       out  1       1 while state != IDLE
//  mem_en     out  1       memory access active
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid when mem_ready=1
//  mem_ready  in   1       memory completes access in the current cycle
// BEHAVIOUR
//  - All outputs registered. Reset value 0 for every output, state=IDLE, last_owner=IF.
//  - States: IDLE -> ACCESS -> RESP -> IDLE.
//    IDLE: if any req, pick owner, latch owner/we/addr/wdata, pulse owner gnt, go ACCESS.
//    ACCESS: mem_en=1, mem_we=latched we (0 for fetch). On mem_ready=1, capture
//      mem_rdata (load/fetch only) and go RESP.
//    RESP: owner *_valid=1 for one cycle; mem_en=0; then IDLE.
//  - Arbitration: one request only -> that requester wins. Both requesting ->
//    the one not granted last (round-robin). After reset, data wins first tie.
//  - Timing: req sampled high in IDLE at edge N -> gnt=1 and mem_en=1 in cycle
//    N+1. mem_ready=1 in that cycle -> valid=1 in N+2, IDLE in N+3.
//    Minimum 3 cycles per access; each wait state adds 1 cycle.
//  - gnt and valid never overlap. At most one of if_* / d_* asserted per cycle.
//  - Requester inputs ignored outside IDLE. Request deasserted before grant = never served.
//  - Store completion pulses d_valid and leaves d_rdata unchanged.
//  - mem_ready outside ACCESS is ignored.
//  - Reset mid-access: immediate return to IDLE, outputs 0, access dropped,
//    no valid pulse.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: a wait counter clears on entry to ACCESS and counts
//    each ACCESS cycle with mem_ready=0. When it reaches TIMEOUT_CYC, go RESP
//    with err=1 alongside the owner valid. Rdata regs unchanged.
//    Counter width $clog2(TIMEOUT_CYC+1).
//  MEM_TIMEOUT_EN undefined: waits forever; err tied 0; no counter logic.
// TESTING
//  1 reset: rst=1 mid-ACCESS -> all outputs 0 at once; idle after release,
//    no stray valid.
//  2 fetch, no wait: if_req, if_addr=0x10, mem_ready=1, mem_rdata=0xE3A01005
//    -> if_gnt @N+1, if_valid @N+2, if_rdata=0xE3A01005.
//  3 store, 2 wait states: d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF
//    -> mem_we=1 and mem_wdata held for 3 cycles; d_valid @N+4; d_rdata unchanged.
//  4 contention: if_req and d_req held high after reset -> grant order D,IF,D,IF;
//    each access completes before the next grant.
//  5 timeout (MEM_TIMEOUT_EN, TIMEOUT_CYC=4): load, mem_ready=0
//    -> d_valid=1, err=1 after 4 ACCESS cycles.
//    Without the macro: stays busy until mem_ready.
//  6 late ready: mem_ready=1 while IDLE -> no effect. Request dropped before
//    grant window -> no gnt.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter: shares one memory port between fetch and data requesters |
// | Optional: `define MEM_TIMEOUT_EN to abort accesses stuck in wait states.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_resp   = 2'd2;
  localparam logic       c_own_if    = 1'b0;
  localparam logic       c_own_d     = 1'b1;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_owner;      // owner of the current / most recent access
  logic       w_req_any;
  logic       w_grant_d;
  logic       w_timeout;

  assign w_req_any = if_req | d_req;
  // Data wins unless the fetch side is also asking and data went last.
  assign w_grant_d = d_req & (~if_req | (r_owner == c_own_if));

`ifdef MEM_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);
  logic [c_cnt_w-1:0] r_wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state != c_st_access) begin
      r_wait_cnt <= '0;
    end else if (!mem_ready) begin
      r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
    end
  end

  // Abort on the wait cycle that brings the count up to TIMEOUT_CYC.
  assign w_timeout = (r_state == c_st_access) && !mem_ready &&
                     (r_wait_cnt == c_cnt_w'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= w_timeout;
    end
  end
`else
  // Never true: without the timeout build an access waits for mem_ready forever.
  assign w_timeout = (TIMEOUT_CYC < 0);
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (w_req_any) w_state_nxt = c_st_access;
      c_st_access: if (mem_ready || w_timeout) w_state_nxt = c_st_resp;
      c_st_resp:   w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner   <= c_own_if;
      if_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt   <= 1'b0;
      d_gnt    <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      busy     <= (w_state_nxt != c_st_idle);
      case (r_state)
        c_st_idle: begin
          if (w_req_any) begin
            r_owner  <= w_grant_d;
            if_gnt   <= ~w_grant_d;
            d_gnt    <= w_grant_d;
            mem_en   <= 1'b1;
            mem_we   <= w_grant_d & d_we;
            mem_addr <= w_grant_d ? d_addr : if_addr;
            if (w_grant_d) mem_wdata <= d_wdata;
          end
        end
        c_st_access: begin
          if (mem_ready || w_timeout) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (r_owner == c_own_d) d_valid  <= 1'b1;
            else                    if_valid <= 1'b1;
            // mem_we still holds the latched direction of this access.
            if (mem_ready && !mem_we) begin
              if (r_owner == c_own_d) d_rdata  <= mem_rdata;
              else                    if_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
